ysyx_23060221_axi_sram: RTL and testbench
=========================================

# ysyx_23060221_axi_sram

AXI4 responder that backs the core's fetch and load/store masters with an on-chip word-addressed SRAM. It accepts one read or write transaction at a time, inserts a programmable access latency to emulate slow memory, and supports FIXED and INCR bursts of up to 256 beats. It sits on the far side of the AXI link from the IFU and LSU masters, directly or behind the arbiter.

## Interface
- `BASE`, 32'h8000_0000: byte address of word 0.
- `ADDR_W`, 12: log2 of the number of 32-bit words in the array.
- `LAT`, 2: access latency in cycles, inserted once per transaction; range 0-15.
- `clk`  in  1  clock, all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to `clk`.
- `awvalid/awready`  in/out  1/1  write-address handshake.
- `awaddr` in 32, `awid` in 4, `awlen` in 8, `awsize` in 3, `awburst` in 2: write-address payload.
- `wvalid/wready`  in/out  1/1  write-data handshake.
- `wdata` in 32, `wstrb` in 4, `wlast` in 1: write-data payload.
- `bvalid/bready`  out/in  1/1  write-response handshake.
- `bresp` out 2, `bid` out 4: write-response payload.
- `arvalid/arready`  in/out  1/1  read-address handshake.
- `araddr` in 32, `arid` in 4, `arlen` in 8, `arsize` in 3, `arburst` in 2: read-address payload.
- `rvalid/rready`  out/in  1/1  read-data handshake.
- `rdata` out 32, `rresp` out 2, `rlast` out 1, `rid` out 4: read-data payload.

## Operation
- The FSM has six states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, WR_RESP.
- IDLE behaviour:
  - `arready` = 1.
  - `awready` = ~`arvalid`, so reads win when AR and AW arrive in the same cycle.
  - An AR handshake latches id, len, size, burst and addr, then goes to RD_WAIT (or straight to RD_DATA when `LAT`=0).
  - An AW handshake latches the same fields and goes to WR_DATA.
- RD_WAIT: a countdown of `LAT` cycles, then RD_DATA.
- RD_DATA:
  - `rvalid`=1. `rdata`, `rresp`, `rid` and `rlast` are registered and held stable until `rready`.
  - Each handshake advances the beat counter. On the beat where count == len, `rlast`=1, and its handshake returns the FSM to IDLE.
- WR_DATA:
  - `wready`=1. Each handshake writes the byte lanes selected by `wstrb` when the transaction is error-free.
  - After len+1 beats the FSM goes to WR_WAIT (`LAT` cycles), then WR_RESP.
- WR_RESP: `bvalid`=1 and `bresp`/`bid` are held until `bready`; the handshake returns the FSM to IDLE.
- Address per beat:
  - INCR (2'b01): latched address + 4·beat.
  - FIXED (2'b00): latched address for every beat.
  - Word index = (addr − `BASE`)[ADDR_W+1:2]. Address bits [1:0] are ignored.
- Response codes:
  - OKAY = 2'b00.
  - SLVERR = 2'b10 when size ≠ 3'b010 or burst ∈ {2'b10, 2'b11}.
  - DECERR = 2'b11 when the beat address falls outside [`BASE`, `BASE`+4·2^ADDR_W).
  - SLVERR takes precedence over DECERR.
- Read errors are reported per beat, with `rdata`=0 on error beats.
- Write errors:
  - `bresp` is the highest-precedence error seen on any beat.
  - Errored beats do not modify memory.
  - A `wlast` value that disagrees with (count == len) forces `bresp` to at least SLVERR. The burst still completes by count.
- `bid` = latched `awid`; `rid` = latched `arid`.

## Timing
- Reset values: `arready`=0, `awready`=0, `wready`=0, `rvalid`=0, `bvalid`=0, `rlast`=0; `rdata`, `rresp`, `bresp`, `rid`, `bid` = 0; FSM in IDLE.
- The memory array is not reset; its contents survive a reset.
- `arready`/`awready` are high from the first cycle after reset deasserts.
- Read latency: AR handshake at cycle T gives the first `rvalid` at T+1+`LAT`.
- Read throughput: with `rready` held high, subsequent beats follow every cycle; a burst of N beats completes at T+`LAT`+N.
- Write latency: AW handshake at T gives `wready` high from T+1. The final W handshake at cycle U gives `bvalid` at U+1+`LAT`.
- After the closing R or B handshake, the FSM is back in IDLE the next cycle, with `arready` high in that cycle.
- Back-pressure: an R or B payload never changes while valid is high and ready is low.
- Ready signals are never asserted outside their state, e.g. `wready`=0 in IDLE even if `wvalid`=1.
- Reset mid-transaction: all valid/ready outputs drop asynchronously, the pending transaction is abandoned with no response issued, and partial write beats already committed remain in memory.

## Test plan
- Single read, `LAT`=2: prewrite word 0 = 32'hDEAD_BEEF; AR handshake at cycle 10 with araddr=32'h8000_0000, arlen=0 -> `rvalid` at cycle 13, `rdata`=32'hDEAD_BEEF, `rresp`=0, `rlast`=1, `rid`=arid.
- INCR write then read-back:
  - Write: awaddr=32'h8000_0010, awlen=3, data 1..4, `wstrb`=4'hF -> one `bvalid` with `bresp`=0, issued `LAT`+1 cycles after the last W beat.
  - Read the same burst back with `rready` toggled every cycle -> data 1..4 in order, each beat held stable while stalled, `rlast` only on beat 4.
- Byte strobes: write 32'h1122_3344 with `wstrb`=4'b0101 over a word holding 0 -> read returns 32'h0022_0044.
- Errors:
  - araddr=32'h7FFF_FFFC -> `rresp`=2'b11, `rdata`=0.
  - arsize=3'b001 -> `rresp`=2'b10.
  - Write to an out-of-range address -> `bresp`=2'b11 and memory unchanged.
- Same-cycle AR and AW: arvalid and awvalid both high in IDLE -> read served first with `awready`=0; AW accepted in the cycle after the `rlast` handshake.
- Reset mid-burst: `rst` low during beat 2 of a 4-beat read -> `rvalid`=0 immediately. After release, a new read of word 0 returns its pre-reset contents.

Source files
------------

// File: rtl/ysyx_23060221_axi_sram.sv
// AXI4 responder backed by a word-addressed SRAM; one transaction at a time, fixed LAT-cycle
// access delay per transaction, FIXED/INCR bursts up to 256 beats with per-beat error checks.
module ysyx_23060221_axi_sram #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          ADDR_W = 12,
  parameter int          LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_WAIT, WR_RESP} state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [3:0] LAT_M1 = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

  function automatic logic [1:0] beat_err(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [1:0] bu);
    logic [31:0] off;
    off = a - BASE;
    if (sz != 3'b010 || bu[1]) return SLVERR;
    if (a < BASE || off >= (32'd4 << ADDR_W)) return DECERR;
    return OKAY;
  endfunction

  // SLVERR outranks DECERR even though its encoding is numerically smaller.
  function automatic logic [1:0] merge(input logic [1:0] a, input logic [1:0] b);
    if (a == SLVERR || b == SLVERR) return SLVERR;
    if (a == DECERR || b == DECERR) return DECERR;
    return OKAY;
  endfunction

  logic [31:0] mem [0:(1 << ADDR_W) - 1];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [7:0]  len_q, beat_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [31:0] baddr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic        rlast_q;
  logic [3:0]  rid_q, bid_q;

  logic        fetch, f_last;
  logic [31:0] f_addr;
  logic [2:0]  f_size;
  logic [1:0]  f_burst;
  logic [1:0]  f_err, w_err, w_resp;
  logic        we;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [31:0] next_baddr;

  assign next_baddr = (burst_q == 2'b01) ? baddr_q + 32'd4 : baddr_q;

  always_comb begin
    state_d = state_q;
    fetch   = 1'b0;
    f_addr  = baddr_q;
    f_size  = size_q;
    f_burst = burst_q;
    f_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arvalid) begin
          state_d = (LAT == 0) ? RD_DATA : RD_WAIT;
          if (LAT == 0) begin
            fetch   = 1'b1;
            f_addr  = araddr;
            f_size  = arsize;
            f_burst = arburst;
            f_last  = (arlen == 8'd0);
          end
        end else if (awvalid) begin
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RD_DATA;
          fetch   = 1'b1;
          f_last  = (len_q == 8'd0);
        end
      end
      RD_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            state_d = IDLE;
          end else begin
            fetch  = 1'b1;
            f_addr = next_baddr;
            f_last = (beat_q + 8'd1 == len_q);
          end
        end
      end
      WR_DATA: begin
        if (wvalid && beat_q == len_q) state_d = (LAT == 0) ? WR_RESP : WR_WAIT;
      end
      WR_WAIT: begin
        if (cnt_q == 4'd0) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign f_err  = beat_err(f_addr, f_size, f_burst);
  assign w_err  = beat_err(baddr_q, size_q, burst_q);
  // A misplaced wlast taints the response but does not block the byte writes.
  assign w_resp = merge(w_err, (wlast != (beat_q == len_q)) ? SLVERR : OKAY);
  assign r_idx  = ADDR_W'((f_addr - BASE) >> 2);
  assign w_idx  = ADDR_W'((baddr_q - BASE) >> 2);
  assign we     = (state_q == WR_DATA) && wvalid && (w_err == OKAY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
      baddr_q <= '0;
      rdata_q <= '0;
      rresp_q <= OKAY;
      rlast_q <= 1'b0;
      rid_q   <= '0;
      bresp_q <= OKAY;
      bid_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && arvalid) begin
        rid_q   <= arid;
        len_q   <= arlen;
        size_q  <= arsize;
        burst_q <= arburst;
        baddr_q <= araddr;
        beat_q  <= '0;
        cnt_q   <= LAT_M1;
      end else if (state_q == IDLE && awvalid) begin
        bid_q   <= awid;
        len_q   <= awlen;
        size_q  <= awsize;
        burst_q <= awburst;
        baddr_q <= awaddr;
        beat_q  <= '0;
        cnt_q   <= LAT_M1;
        bresp_q <= OKAY;
      end
      if ((state_q == RD_WAIT || state_q == WR_WAIT) && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
      if (fetch) begin
        baddr_q <= f_addr;
        rdata_q <= (f_err == OKAY) ? mem[r_idx] : 32'd0;
        rresp_q <= f_err;
        rlast_q <= f_last;
      end
      if (state_q == RD_DATA && rready && !rlast_q) beat_q <= beat_q + 8'd1;
      if (state_q == WR_DATA && wvalid) begin
        beat_q  <= beat_q + 8'd1;
        baddr_q <= next_baddr;
        bresp_q <= merge(bresp_q, w_resp);
        if (beat_q == len_q) cnt_q <= LAT_M1;
      end
    end
  end

  // The array has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign arready = rst && (state_q == IDLE);
  assign awready = rst && (state_q == IDLE) && !arvalid;
  assign wready  = (state_q == WR_DATA);
  assign rvalid  = (state_q == RD_DATA);
  assign bvalid  = (state_q == WR_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign bresp   = bresp_q;
  assign bid     = bid_q;

endmodule

// File: tb/tb_ysyx_23060221_axi_sram.sv
// Directed bench for the AXI SRAM responder: latency, bursts, strobes, errors, arbitration, reset.
module tb_ysyx_23060221_axi_sram;
  localparam int LAT = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  int checks = 0;
  int errors = 0;
  logic [31:0] wd [0:7];
  logic [31:0] ed [0:7];
  logic [1:0]  er [0:7];

  ysyx_23060221_axi_sram #(.BASE(BASE), .ADDR_W(12), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input logic [31:0] got, input logic [31:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [7:0] len, input logic [1:0] bu,
                          input logic [3:0] id, input logic [3:0] strb, input logic [1:0] exp,
                          input string tag);
    int n;
    awvalid = 1'b1; awaddr = a; awlen = len; awsize = 3'b010; awburst = bu; awid = id;
    #1;
    check(32'(awready), 32'd1, {tag, "_awready"});
    tick();
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1'b1; wdata = wd[b]; wstrb = strb; wlast = (b == int'(len));
      #1;
      check(32'(wready), 32'd1, {tag, "_wready"});
      tick();
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    check(32'(n), 32'(LAT), {tag, "_b_latency"});
    check(32'(bresp), 32'(exp), {tag, "_bresp"});
    check(32'(bid), 32'(id), {tag, "_bid"});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check(32'(bvalid), 32'd0, {tag, "_bvalid_drop"});
    check(32'(arready), 32'd1, {tag, "_idle_after_b"});
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id, input bit stall,
                         input string tag);
    int n;
    arvalid = 1'b1; araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id;
    rready = 1'b0;
    #1;
    check(32'(arready), 32'd1, {tag, "_arready"});
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    check(32'(n), 32'(LAT), {tag, "_r_latency"});
    for (int b = 0; b <= int'(len); b++) begin
      if (stall) begin
        rready = 1'b0;
        tick();
      end
      rready = 1'b1;
      #1;
      check(32'(rvalid), 32'd1, {tag, $sformatf("_rvalid%0d", b)});
      check(rdata, ed[b], {tag, $sformatf("_rdata%0d", b)});
      check(32'(rresp), 32'(er[b]), {tag, $sformatf("_rresp%0d", b)});
      check(32'(rlast), 32'(b == int'(len)), {tag, $sformatf("_rlast%0d", b)});
      check(32'(rid), 32'(id), {tag, $sformatf("_rid%0d", b)});
      tick();
      rready = 1'b0;
    end
    check(32'(rvalid), 32'd0, {tag, "_rvalid_drop"});
    check(32'(arready), 32'd1, {tag, "_idle_after_r"});
  endtask

  initial begin
    int n;
    rst = 1'b0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    #3;
    check(32'(arready), 32'd0, "rst_arready");
    check(32'(awready), 32'd0, "rst_awready");
    check(32'(wready), 32'd0, "rst_wready");
    check(32'(rvalid), 32'd0, "rst_rvalid");
    check(32'(bvalid), 32'd0, "rst_bvalid");
    check(32'(rlast), 32'd0, "rst_rlast");
    check(rdata, 32'd0, "rst_rdata");
    check(32'({rresp, bresp, rid, bid}), 32'd0, "rst_resp_ids");
    tick(); tick();
    rst = 1'b1;
    #1;
    check(32'(arready), 32'd1, "post_rst_arready");
    check(32'(awready), 32'd1, "post_rst_awready");
    wvalid = 1'b1;
    #1;
    check(32'(wready), 32'd0, "idle_wready");
    wvalid = 1'b0;
    tick();

    // single write then single read of word 0
    wd[0] = 32'hDEAD_BEEF;
    do_write(BASE, 8'd0, 2'b01, 4'd1, 4'hF, 2'b00, "wr_word0");
    ed[0] = 32'hDEAD_BEEF; er[0] = 2'b00;
    do_read(BASE, 8'd0, 3'b010, 2'b01, 4'd5, 1'b0, "rd_word0");

    // INCR burst write and stalled read-back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ed[i] = 32'(i + 1); er[i] = 2'b00; end
    do_write(32'h8000_0010, 8'd3, 2'b01, 4'd3, 4'hF, 2'b00, "wr_incr");
    do_read(32'h8000_0010, 8'd3, 3'b010, 2'b01, 4'd7, 1'b1, "rd_incr");

    // FIXED burst repeats the same word
    ed[0] = 32'd2; ed[1] = 32'd2; er[0] = 2'b00; er[1] = 2'b00;
    do_read(32'h8000_0014, 8'd1, 3'b010, 2'b00, 4'd2, 1'b0, "rd_fixed");

    // byte strobes
    wd[0] = 32'd0;
    do_write(32'h8000_0020, 8'd0, 2'b01, 4'd4, 4'hF, 2'b00, "wr_clear");
    wd[0] = 32'h1122_3344;
    do_write(32'h8000_0020, 8'd0, 2'b01, 4'd4, 4'b0101, 2'b00, "wr_strb");
    ed[0] = 32'h0022_0044; er[0] = 2'b00;
    do_read(32'h8000_0020, 8'd0, 3'b010, 2'b01, 4'd4, 1'b0, "rd_strb");

    // read errors
    ed[0] = 32'd0; er[0] = 2'b11;
    do_read(32'h7FFF_FFFC, 8'd0, 3'b010, 2'b01, 4'd8, 1'b0, "rd_decerr");
    ed[0] = 32'd0; er[0] = 2'b10;
    do_read(BASE, 8'd0, 3'b001, 2'b01, 4'd9, 1'b0, "rd_slverr");

    // out-of-range write leaves the aliasing word 0 alone
    wd[0] = 32'h1234_5678;
    do_write(32'h8000_4000, 8'd0, 2'b01, 4'd6, 4'hF, 2'b11, "wr_decerr");
    ed[0] = 32'hDEAD_BEEF; er[0] = 2'b00;
    do_read(BASE, 8'd0, 3'b010, 2'b01, 4'd1, 1'b0, "rd_unchanged");

    // simultaneous AR and AW: read wins
    awvalid = 1'b1; awaddr = 32'h8000_0030; awlen = 0; awsize = 3'b010; awburst = 2'b01; awid = 4'd9;
    arvalid = 1'b1; araddr = BASE; arlen = 0; arsize = 3'b010; arburst = 2'b01; arid = 4'd6;
    #1;
    check(32'(arready), 32'd1, "both_arready");
    check(32'(awready), 32'd0, "both_awready");
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin
      check(32'(awready), 32'd0, "both_awready_wait");
      tick(); n++;
    end
    check(32'(n), 32'(LAT), "both_r_latency");
    rready = 1'b1;
    #1;
    check(rdata, 32'hDEAD_BEEF, "both_rdata");
    check(32'(rlast), 32'd1, "both_rlast");
    tick();
    rready = 1'b0;
    check(32'(awready), 32'd1, "both_aw_after_r");
    tick();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1;
    #1;
    check(32'(wready), 32'd1, "both_wready");
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin tick(); n++; end
    check(32'(n), 32'(LAT), "both_b_latency");
    check(32'({bresp, bid}), 32'({2'b00, 4'd9}), "both_bresp_bid");
    bready = 1'b1;
    tick();
    bready = 1'b0;
    ed[0] = 32'hCAFE_F00D; er[0] = 2'b00;
    do_read(32'h8000_0030, 8'd0, 3'b010, 2'b01, 4'd3, 1'b0, "rd_after_both");

    // reset during beat 2 of a 4-beat read
    arvalid = 1'b1; araddr = 32'h8000_0010; arlen = 8'd3; arsize = 3'b010; arburst = 2'b01; arid = 4'd2;
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin tick(); n++; end
    check(rdata, 32'd1, "rstmid_beat1");
    tick();
    check(rdata, 32'd2, "rstmid_beat2");
    rst = 1'b0;
    #1;
    check(32'(rvalid), 32'd0, "rstmid_rvalid");
    check(32'(arready), 32'd0, "rstmid_arready");
    rready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check(32'(arready), 32'd1, "rstmid_release");
    tick();
    ed[0] = 32'hDEAD_BEEF; er[0] = 2'b00;
    do_read(BASE, 8'd0, 3'b010, 2'b01, 4'd5, 1'b0, "rd_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
